debug_panel: RTL and testbench
==============================

# debug_panel

Parametrised seven-segment debug display controller that replaces per-digit static decoding at the top level. It accepts `CHANNELS` debug words of `DIGITS` hex nibbles each and shows one page at a time on the `DIGITS`-digit segment bus. Pages are selected with a debounced push-button or by automatic rotation, and a freeze input holds the displayed value. It sits between the debug buses of the camera, SCCB and VGA blocks and the board LED pins.

## Interface
- `DIGITS`, 8, number of displayed hex digits (≥1)
- `CHANNELS`, 4, number of debug pages (≥1)
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles before a button level is accepted (≥1)
- `ROTATE_CYCLES`, 0, auto page-advance period in cycles; 0 disables rotation
- `LZ_BLANK`, 0, 1 blanks leading zero digits; digit 0 is never blanked
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: asynchronous, active-low reset
- `debug_in` in `CHANNELS*DIGITS*4`: page p occupies bits `[(p+1)*DIGITS*4-1 : p*DIGITS*4]`; nibble 0 is the rightmost digit
- `page_btn` in 1: raw button, active-high, asynchronous to `clk`
- `freeze` in 1: raw level, active-high, asynchronous to `clk`
- `led` out `DIGITS*7`: digit d is on `led[d*7+6 : d*7]`; bit 0 = segment a … bit 6 = segment g; 1 = lit
- `page` out `PW = max(1, clog2(CHANNELS))`: currently selected page

## Operation
- **Synchronisers:** `page_btn` and `freeze` each pass through a 2-flop synchroniser, reset to 0.
- **Debounce:**
  - Counter compares the synchronised button against the accepted level `btn_db`. The counter clears whenever they are equal.
  - The counter increments while they differ. When it reaches `DEBOUNCE_CYCLES-1` and they still differ, `btn_db` toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` is ignored.
- **Page advance:**
  - An advance event is a rising edge of `btn_db` (registered previous value) or a rotate tick.
  - The page increments by 1; `CHANNELS-1` wraps to 0. With `CHANNELS=1` the page stays 0.
  - Button edge and rotate tick in the same cycle produce one increment only.
- **Rotation:**
  - Active only when `ROTATE_CYCLES>0`. The counter counts 0…`ROTATE_CYCLES-1` and ticks on the terminal count.
  - A button advance clears the rotate counter to 0.
- **Snapshot register:**
  - `snap[DIGITS*4-1:0]` loads page `page` of `debug_in` every cycle while the synchronised freeze is 0.
  - While frozen, `snap` holds. Exception: it loads once in the cycle after a page change, so a new page still shows fresh data and then freezes.
- **Encoder:**
  - Hex to segments, registered: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - With `LZ_BLANK=1`, digit d>0 outputs 00 when it and all higher nibbles are 0.

## Timing
- **Reset values:** `page`=0, `snap`=0, `btn_db`=0, all counters 0, synchronisers 0. `led` = all zero (blank), not the code for "0".
- **Data path:** `debug_in` → `snap` (1 cycle) → `led` (1 cycle); latency 2 cycles when not frozen.
- **Button:** raw rise → `page` increment takes 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge register) cycles. New-page data appears on `led` 2 cycles after `page` changes.
- **Freeze:** effective 2 cycles after the raw change. `led` stops changing 1 cycle later.
- **Reset mid-operation:** all state returns to reset values immediately and asynchronously; a button held through reset release is not an edge until it is released and pressed again.
- **Release:** a released button must also debounce; bounces during release never advance the page.

## Test plan
- Reset with `debug_in` nonzero → `led`=0 and `page`=0 during reset; 2 cycles after release, `led` shows page-0 nibbles (e.g. 0x1234ABCD → digit0=5E, digit7=06).
- `DEBOUNCE_CYCLES=4`: raw pulse of 3 cycles → `page` stays 0; pulse of 8 cycles → `page`=1 exactly 7 cycles after the rise; 4 presses with `CHANNELS=4` → wraps to 0.
- `ROTATE_CYCLES=10`, no button → `page` steps 0,1,2,3,0 every 10 cycles. A button edge coinciding with a tick → a single increment, and the next tick follows 10 cycles later.
- Freeze high, `debug_in` changing → `led` constant. Page advance while frozen → `led` shows the new page value captured once, then holds. Freeze low → `led` tracks input again 3 cycles later.
- `LZ_BLANK=1`, page value 0x00000070 → digits 7..2 = 00, digit1=07, digit0=3F; value 0 → only digit0=3F.
- Assert `rst` in the middle of a debounce count → after release, a single button press needs the full `DEBOUNCE_CYCLES` and advances `page` from 0 to 1.

Source files
------------

// File: rtl/debug_panel_if.sv
// Debug panel bus: debug words in, button/freeze controls in, segment bus and page number out.
interface debug_panel_if #(
   parameter int DIGITS   = 8,
   parameter int CHANNELS = 4
);
   localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS*DIGITS*4-1:0] debug_in;
   logic                         page_btn;
   logic                         freeze;
   logic [DIGITS*7-1:0]          led;
   logic [PW-1:0]                page;

   modport master (output debug_in, page_btn, freeze, input led, page);
   modport slave  (input debug_in, page_btn, freeze, output led, page);
endinterface

// File: rtl/debug_panel.sv
// Paged seven-segment debug display: debounced page button, optional auto-rotation,
// freeze with one-shot reload on page change, optional leading-zero blanking.
module debug_panel #(
   parameter int DIGITS          = 8,
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int ROTATE_CYCLES   = 0,
   parameter int LZ_BLANK        = 0
) (
   input logic          clk,
   input logic          rst,
   debug_panel_if.slave bus
);
   localparam int PW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int DW  = DIGITS * 4;
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RW  = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0]  ROT_LAST  = RW'((ROTATE_CYCLES > 0) ? ROTATE_CYCLES - 1 : 0);
   localparam logic [PW-1:0]  PAGE_LAST = PW'(CHANNELS - 1);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Scan from the most significant digit so "lead" stays set only across leading zeros.
   function automatic logic [DIGITS*7-1:0] encode(input logic [DW-1:0] v);
      logic [DIGITS*7-1:0] seg;
      logic                lead;
      seg  = '0;
      lead = 1'b1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         if (v[d*4 +: 4] != 4'h0) lead = 1'b0;
         if (LZ_BLANK != 0 && lead && d != 0) seg[d*7 +: 7] = 7'h00;
         else                                 seg[d*7 +: 7] = hex7(v[d*4 +: 4]);
      end
      return seg;
   endfunction

   logic                btn_s1, btn_s2, frz_s1, frz_s2;
   logic [1:0]          fill;
   logic                armed;
   logic [DBW-1:0]      db_cnt;
   logic                btn_db, btn_prev;
   logic [RW-1:0]       rot_cnt;
   logic [PW-1:0]       page_r;
   logic                page_chg;
   logic [DW-1:0]       snap_p0;
   logic [DIGITS*7-1:0] led_p1;
   logic                btn_adv, rot_tick, advance, snap_load;

   assign btn_adv   = armed & btn_db & ~btn_prev;
   assign rot_tick  = (ROTATE_CYCLES > 0) && (rot_cnt == ROT_LAST);
   assign advance   = btn_adv | rot_tick;
   assign snap_load = ~frz_s2 | page_chg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         frz_s1 <= 1'b0;
         frz_s2 <= 1'b0;
      end else begin
         btn_s1 <= bus.page_btn;
         btn_s2 <= btn_s1;
         frz_s1 <= bus.freeze;
         frz_s2 <= frz_s1;
      end
   end

   // Edges count only once the synchronised button has been seen low after reset,
   // so a button held through reset release does not advance the page.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill     <= 2'b00;
         armed    <= 1'b0;
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_prev <= 1'b0;
      end else begin
         fill     <= {fill[0], 1'b1};
         btn_prev <= btn_db;
         if (fill[1] && !btn_s2) armed <= 1'b1;
         if (btn_s2 == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_db <= ~btn_db;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DBW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         page_r   <= '0;
         page_chg <= 1'b0;
         rot_cnt  <= '0;
      end else begin
         page_chg <= advance;
         if (advance) page_r <= (page_r == PAGE_LAST) ? '0 : page_r + PW'(1);
         if (ROTATE_CYCLES == 0 || btn_adv || rot_tick) rot_cnt <= '0;
         else                                          rot_cnt <= rot_cnt + RW'(1);
      end
   end

   // Stage p0: page snapshot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           snap_p0 <= '0;
      else if (snap_load) snap_p0 <= bus.debug_in[int'(page_r) * DW +: DW];
   end

   // Stage p1: segment encode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) led_p1 <= '0;
      else      led_p1 <= encode(snap_p0);
   end

   assign bus.led  = led_p1;
   assign bus.page = page_r;
endmodule

// File: tb/tb_debug_panel.sv
// Scoreboard bench for debug_panel: one instance for debounce/freeze/reset, one for rotation/blanking.
module tb_debug_panel;
   localparam int A_LED = 0, A_PAGE = 1, B_LED = 2, B_PAGE = 3;

   localparam logic [31:0] P0 = 32'h1234ABCD;
   localparam logic [31:0] P1 = 32'h89EF0567;
   localparam logic [31:0] P2 = 32'h00000070;
   localparam logic [31:0] P3 = 32'hFEDCBA98;
   localparam logic [55:0] L_P0 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h77, 7'h7C, 7'h39, 7'h5E};
   localparam logic [55:0] L_P1 = {7'h7F, 7'h6F, 7'h79, 7'h71, 7'h3F, 7'h6D, 7'h7D, 7'h07};
   localparam logic [55:0] L_P2 = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h07, 7'h3F};
   localparam logic [55:0] L_P3 = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};
   localparam logic [55:0] L_Z  = {8{7'h3F}};
   localparam logic [55:0] LZ_70   = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h07, 7'h3F};
   localparam logic [55:0] LZ_0    = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F};
   localparam logic [55:0] LZ_1000 = {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
   localparam logic [55:0] LZ_A0B  = {7'h00, 7'h00, 7'h77, 7'h3F, 7'h3F, 7'h7C, 7'h3F, 7'h3F};

   typedef struct {
      int          cyc;
      int          sel;
      logic [55:0] exp;
      string       name;
   } chk_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   bit   done_a = 1'b0;
   bit   done_b = 1'b0;
   chk_t sb[$];
   logic [31:0] a_pg [4];

   debug_panel_if #(.DIGITS(8), .CHANNELS(4)) ifa ();
   debug_panel_if #(.DIGITS(8), .CHANNELS(4)) ifb ();

   debug_panel #(.DIGITS(8), .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ROTATE_CYCLES(0), .LZ_BLANK(0))
      u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
   debug_panel #(.DIGITS(8), .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ROTATE_CYCLES(10), .LZ_BLANK(1))
      u_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic push(input int c, input int sel, input logic [55:0] e, input string n);
      chk_t k;
      k.cyc = c; k.sel = sel; k.exp = e; k.name = n;
      sb.push_back(k);
   endtask

   task automatic set_a();
      ifa.debug_in = {a_pg[3], a_pg[2], a_pg[1], a_pg[0]};
   endtask

   // Monitor: compare every entry whose cycle has come
   always @(negedge clk) begin : mon
      logic [55:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            case (sb[i].sel)
               A_LED:   act = ifa.led;
               A_PAGE:  act = 56'(ifa.page);
               B_LED:   act = ifb.led;
               default: act = 56'(ifb.page);
            endcase
            n_total++;
            if (sb[i].cyc == cyc && act === sb[i].exp) n_pass++;
            else $display("FAIL %s cyc=%0d: got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
            sb.delete(i);
         end
      end
   end

   initial begin : stim_a
      int t;
      logic [31:0] dp_v [3];
      logic [55:0] dp_l [3];
      logic [55:0] prev_l;
      int          ex_p [3];
      logic [55:0] ex_l [3];
      dp_v = '{P3, P1, P0};
      dp_l = '{L_P3, L_P1, L_P0};
      ex_p = '{2, 3, 0};
      ex_l = '{L_P2, L_P3, L_P0};
      rst_a = 1'b0;
      ifa.page_btn = 1'b0;
      ifa.freeze = 1'b0;
      a_pg = '{P0, P1, P2, P3};
      set_a();
      wait_to(2);
      push(4, A_LED, '0, "a_rst_led");
      push(4, A_PAGE, '0, "a_rst_page");
      wait_to(5);
      rst_a = 1'b1;
      push(6, A_LED, L_Z, "a_snap_zero");
      push(7, A_LED, L_P0, "a_first_data");
      push(7, A_PAGE, '0, "a_page0");
      wait_to(10);
      prev_l = L_P0;
      for (int i = 0; i < 3; i++) begin
         t = cyc;
         a_pg[0] = dp_v[i];
         set_a();
         push(t + 1, A_LED, prev_l, "a_dp_old");
         push(t + 2, A_LED, dp_l[i], "a_dp_new");
         prev_l = dp_l[i];
         wait_to(t + 4);
      end
      // 3-cycle pulse is shorter than the debounce window
      t = cyc;
      ifa.page_btn = 1'b1;
      wait_to(t + 3);
      ifa.page_btn = 1'b0;
      push(t + 12, A_PAGE, '0, "a_short_pulse");
      wait_to(t + 16);
      // 8-cycle press with bouncy release
      t = cyc;
      ifa.page_btn = 1'b1;
      push(t + 6, A_PAGE, 56'd0, "a_pre_edge");
      push(t + 7, A_PAGE, 56'd1, "a_edge");
      push(t + 8, A_LED, L_P0, "a_led_old_page");
      push(t + 9, A_LED, L_P1, "a_led_new_page");
      wait_to(t + 8);  ifa.page_btn = 1'b0;
      wait_to(t + 10); ifa.page_btn = 1'b1;
      wait_to(t + 11); ifa.page_btn = 1'b0;
      wait_to(t + 12); ifa.page_btn = 1'b1;
      wait_to(t + 13); ifa.page_btn = 1'b0;
      push(t + 30, A_PAGE, 56'd1, "a_release_bounce");
      wait_to(t + 34);
      // three more presses, each with a 2-cycle dropout while held; wraps to 0
      for (int k = 0; k < 3; k++) begin
         t = cyc;
         ifa.page_btn = 1'b1;
         push(t + 7, A_PAGE, 56'(ex_p[k]), "a_press_page");
         push(t + 9, A_LED, ex_l[k], "a_press_led");
         wait_to(t + 8);  ifa.page_btn = 1'b0;
         wait_to(t + 10); ifa.page_btn = 1'b1;
         wait_to(t + 20); ifa.page_btn = 1'b0;
         push(t + 30, A_PAGE, 56'(ex_p[k]), "a_hold_glitch");
         wait_to(t + 34);
      end
      // freeze, page change while frozen, unfreeze
      t = cyc;
      ifa.freeze = 1'b1;
      wait_to(t + 1);
      a_pg[0] = P3;
      set_a();
      push(t + 3, A_LED, L_P3, "a_frz_last_load");
      push(t + 8, A_LED, L_P3, "a_frz_hold");
      wait_to(t + 3);
      a_pg[0] = P1;
      a_pg[1] = P2;
      set_a();
      wait_to(t + 10);
      ifa.page_btn = 1'b1;
      push(t + 16, A_PAGE, 56'd0, "a_frz_pre_page");
      push(t + 17, A_PAGE, 56'd1, "a_frz_page");
      push(t + 18, A_LED, L_P3, "a_frz_before_new");
      push(t + 19, A_LED, L_P2, "a_frz_new_page");
      wait_to(t + 18);
      ifa.page_btn = 1'b0;
      wait_to(t + 22);
      a_pg[1] = P0;
      set_a();
      push(t + 27, A_LED, L_P2, "a_frz_hold_new");
      wait_to(t + 30);
      ifa.freeze = 1'b0;
      push(t + 35, A_LED, L_P0, "a_unfreeze");
      wait_to(t + 36);
      a_pg[1] = P3;
      set_a();
      push(t + 38, A_LED, L_P3, "a_track");
      wait_to(t + 44);
      // button held through reset release gives no edge
      t = cyc;
      ifa.page_btn = 1'b1;
      wait_to(t + 2);
      rst_a = 1'b0;
      push(t + 3, A_PAGE, '0, "a_rst_hold_page");
      push(t + 3, A_LED, '0, "a_rst_hold_led");
      wait_to(t + 4);
      rst_a = 1'b1;
      push(t + 20, A_PAGE, '0, "a_held_no_edge");
      wait_to(t + 22);
      ifa.page_btn = 1'b0;
      wait_to(t + 34);
      t = cyc;
      ifa.page_btn = 1'b1;
      push(t + 7, A_PAGE, 56'd1, "a_repress");
      wait_to(t + 8);
      ifa.page_btn = 1'b0;
      wait_to(t + 20);
      // reset in the middle of a debounce count
      t = cyc;
      ifa.page_btn = 1'b1;
      wait_to(t + 4);
      rst_a = 1'b0;
      ifa.page_btn = 1'b0;
      push(t + 5, A_PAGE, '0, "a_mid_rst_page");
      wait_to(t + 6);
      rst_a = 1'b1;
      wait_to(t + 8);
      t = cyc;
      ifa.page_btn = 1'b1;
      push(t + 6, A_PAGE, 56'd0, "a_mid_rst_pre");
      push(t + 7, A_PAGE, 56'd1, "a_mid_rst_edge");
      wait_to(t + 8);
      ifa.page_btn = 1'b0;
      wait_to(t + 20);
      done_a = 1'b1;
   end

   initial begin : stim_b
      rst_b = 1'b0;
      ifb.page_btn = 1'b0;
      ifb.freeze = 1'b0;
      ifb.debug_in = {4{P2}};
      wait_to(2);
      push(4, B_LED, '0, "b_rst_led");
      push(4, B_PAGE, '0, "b_rst_page");
      wait_to(5);
      rst_b = 1'b1;
      push(6, B_LED, LZ_0, "b_lz_zero");
      push(7, B_LED, LZ_70, "b_lz_70");
      push(14, B_PAGE, 56'd0, "b_rot_pre");
      push(15, B_PAGE, 56'd1, "b_rot_1");
      push(24, B_PAGE, 56'd1, "b_rot_hold");
      push(25, B_PAGE, 56'd2, "b_rot_2");
      push(35, B_PAGE, 56'd3, "b_rot_3");
      push(44, B_PAGE, 56'd3, "b_rot_hold3");
      push(45, B_PAGE, 56'd0, "b_rot_wrap");
      // button edge lands on the tick at cycle 55
      wait_to(48);
      ifb.page_btn = 1'b1;
      push(54, B_PAGE, 56'd0, "b_coinc_pre");
      push(55, B_PAGE, 56'd1, "b_coinc_single");
      push(64, B_PAGE, 56'd1, "b_coinc_hold");
      push(65, B_PAGE, 56'd2, "b_coinc_next_tick");
      wait_to(56);
      ifb.page_btn = 1'b0;
      // button edge at 70 restarts the rotate period
      wait_to(63);
      ifb.page_btn = 1'b1;
      push(70, B_PAGE, 56'd3, "b_btn_adv");
      push(75, B_PAGE, 56'd3, "b_rot_restart");
      push(79, B_PAGE, 56'd3, "b_rot_pre_tick");
      push(80, B_PAGE, 56'd0, "b_rot_after_btn");
      wait_to(71);
      ifb.page_btn = 1'b0;
      wait_to(82);
      ifb.debug_in = {4{32'h10000000}};
      push(84, B_LED, LZ_1000, "b_lz_top");
      wait_to(86);
      ifb.debug_in = '0;
      push(88, B_LED, LZ_0, "b_lz_all_zero");
      wait_to(90);
      ifb.debug_in = {4{32'h00A00B00}};
      push(92, B_LED, LZ_A0B, "b_lz_inner_zeros");
      wait_to(96);
      done_b = 1'b1;
   end

   initial begin : finish_ctl
      for (int k = 0; k < 5000 && !(done_a && done_b); k++) @(negedge clk);
      for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
      if (!(done_a && done_b) || sb.size() > 0) begin
         n_total++;
         $display("FAIL timeout: done_a=%0d done_b=%0d pending=%0d required all done, 0 pending",
                  done_a, done_b, sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
